// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    input  logic [1:0][2:0]       req_cont,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_cont,
    output logic                  alu_reset,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       cont_q;
    logic             gnt_q;
    logic             grant;
    logic             cont_ok;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // Round-robin: on contention the requester not served last wins
    always_comb begin
        grant = ~req_valid[0];
        if (&req_valid) begin
            grant = ~last_grant;
        end
    end

    // Remember the most recent grant; requester 0 wins first after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && |req_valid) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid
    always_comb begin
        grant = ~req_valid[0];
    end
`endif

    // Accept only in IDLE and never while reset is asserted
    always_comb begin
        req_ready = 2'b00;
        if (reset && state == IDLE && |req_valid) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    // Codes the shared ALU actually implements
    always_comb begin
        case (cont_q)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: cont_ok = 1'b1;
            default:                                cont_ok = 1'b0;
        endcase
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cont  = cont_q;
    assign alu_reset = ~reset;

    // Transaction sequencer with registered operands and response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cont_q     <= 3'b010;
            gnt_q      <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        a_q    <= req_a[grant];
                        b_q    <= req_b[grant];
                        cont_q <= req_cont[grant];
                        gnt_q  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cont_ok) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                    end else begin
                        rsp_result <= '0;
                        rsp_zero   <= 1'b1;
                        rsp_err    <= 1'b1;
                    end
                    rsp_valid <= {gnt_q, ~gnt_q};
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
